// File: rtl/dfb_reg_slave_if.sv
// Falcon-side 68000 bus signals seen by the DFB register slave.
// The master modport is the bus side; the slave modport is the register block.
interface dfb_reg_slave_if;
  logic [23:1] A;
  logic        XAS;
  logic        XUDS;
  logic        XLDS;
  logic        XRW;
  logic [15:0] DIN;
  logic [15:0] DOUT;
  logic        DOE;
  logic        XDTACK_OE;

  modport master (
    output A, XAS, XUDS, XLDS, XRW, DIN,
    input  DOUT, DOE, XDTACK_OE
  );

  modport slave (
    input  A, XAS, XUDS, XLDS, XRW, DIN,
    output DOUT, DOE, XDTACK_OE
  );
endinterface

// File: rtl/dfb_reg_slave.sv
// DFB register slave: synchronizes the asynchronous 68000 strobes, decodes a
// 16-byte window and serves CTRL/STATUS/SCRATCH/ID with a programmable DTACK delay.
module dfb_reg_slave #(
  parameter logic [7:0]  BASE_ADDR   = 8'hF1,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [15:0] ID_VALUE    = 16'hDFB1
) (
  input  logic               XCPUCLK,
  input  logic               RST,
  dfb_reg_slave_if.slave     bus,
  input  logic [7:0]         STATUS_IN,
  output logic [15:0]        CTRL,
  output logic               BUSY
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACK    = 2'd2,
    ST_IGNORE = 2'd3
  } state_t;

  logic [1:0]  as_sync_r;
  logic [1:0]  uds_sync_r;
  logic [1:0]  lds_sync_r;
  logic        as_s;
  logic        uds_s;
  logic        lds_s;

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic [2:0]  off_r;
  logic        rw_r;
  logic        uds_en_r;
  logic        lds_en_r;
  logic [15:0] din_r;
  logic [15:0] ctrl_r;
  logic [15:0] scratch_r;
  logic [15:0] dout_r;
  logic        doe_r;
  logic        dtack_r;
  logic [15:0] rd_data_s;
  logic        hit_s;

  // Merge new write data into a register only on the enabled byte lanes.
  function automatic logic [15:0] merge_lanes(
    input logic [15:0] old_val,
    input logic [15:0] new_val,
    input logic        upper_en,
    input logic        lower_en
  );
    logic [15:0] res;
    res[15:8] = upper_en ? new_val[15:8] : old_val[15:8];
    res[7:0]  = lower_en ? new_val[7:0]  : old_val[7:0];
    return res;
  endfunction

  assign as_s  = as_sync_r[1];
  assign uds_s = uds_sync_r[1];
  assign lds_s = lds_sync_r[1];
  assign hit_s = (bus.A[23:16] == BASE_ADDR) && (bus.A[15:4] == 12'h000);

  // Two-flop synchronizers for the asynchronous strobes.
  always_ff @(posedge XCPUCLK) begin
    if (!RST) begin
      as_sync_r  <= 2'b11;
      uds_sync_r <= 2'b11;
      lds_sync_r <= 2'b11;
    end else begin
      as_sync_r  <= {as_sync_r[0], bus.XAS};
      uds_sync_r <= {uds_sync_r[0], bus.XUDS};
      lds_sync_r <= {lds_sync_r[0], bus.XLDS};
    end
  end

  // Read data selected by the offset latched at the start of the cycle.
  always_comb begin
    rd_data_s = 16'h0000;
    case (off_r)
      3'd0:    rd_data_s = ctrl_r;
      3'd1:    rd_data_s = {8'h00, STATUS_IN};
      3'd2:    rd_data_s = scratch_r;
      3'd3:    rd_data_s = ID_VALUE;
      default: rd_data_s = 16'h0000;
    endcase
  end

  // Bus cycle FSM with registered DTACK, DOE, DOUT and register writes.
  always_ff @(posedge XCPUCLK) begin
    if (!RST) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 4'd0;
      off_r     <= 3'd0;
      rw_r      <= 1'b1;
      uds_en_r  <= 1'b0;
      lds_en_r  <= 1'b0;
      din_r     <= 16'h0000;
      ctrl_r    <= 16'h0000;
      scratch_r <= 16'h0000;
      dout_r    <= 16'h0000;
      doe_r     <= 1'b0;
      dtack_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          doe_r   <= 1'b0;
          dtack_r <= 1'b0;
          if (!as_s && (!uds_s || !lds_s)) begin
            if (hit_s) begin
              state_r  <= ST_WAIT;
              off_r    <= bus.A[3:1];
              rw_r     <= bus.XRW;
              uds_en_r <= !uds_s;
              lds_en_r <= !lds_s;
              din_r    <= bus.DIN;
              cnt_r    <= WAIT_LOAD;
            end else begin
              state_r <= ST_IGNORE;
            end
          end
        end
        ST_WAIT: begin
          if (as_s) begin
            // Master gave up before DTACK: drop the cycle without side effects.
            state_r <= ST_IDLE;
          end else if (cnt_r == 4'd0) begin
            state_r <= ST_ACK;
            dtack_r <= 1'b1;
            doe_r   <= rw_r;
            dout_r  <= rd_data_s;
            if (!rw_r) begin
              case (off_r)
                3'd0:    ctrl_r    <= merge_lanes(ctrl_r, din_r, uds_en_r, lds_en_r);
                3'd2:    scratch_r <= merge_lanes(scratch_r, din_r, uds_en_r, lds_en_r);
                default: ctrl_r    <= ctrl_r;
              endcase
            end
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_ACK: begin
          if (as_s) begin
            state_r <= ST_IDLE;
            dtack_r <= 1'b0;
            doe_r   <= 1'b0;
          end
        end
        ST_IGNORE: begin
          doe_r   <= 1'b0;
          dtack_r <= 1'b0;
          if (as_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          doe_r   <= 1'b0;
          dtack_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.DOUT      = dout_r;
  assign bus.DOE       = doe_r;
  assign bus.XDTACK_OE = dtack_r;
  assign CTRL          = ctrl_r;
  assign BUSY          = (state_r != ST_IDLE);

endmodule

// File: doc/dfb_reg_slave.md
DFB_REG_SLAVE -- requirements
Module: dfb_reg_slave

Interface
REQ-001 Parameter BASE_ADDR, default 8'hF1, sets the A[23:16] value that selects the block.
REQ-002 Parameter WAIT_STATES, default 2, range 0-15, sets the extra clocks inserted before DTACK.
REQ-003 Parameter ID_VALUE, default 16'hDFB1, is the read-only board ID.
REQ-004 XCPUCLK  in  1  Single clock; all state changes on its rising edge.
REQ-005 RST  in  1  Reset: synchronous, active-low.
REQ-006 A  in  23  A[23:1] from the Falcon-side 68000 bus, asynchronous to XCPUCLK.
REQ-007 XAS  in  1  Address strobe, active-low, asynchronous.
REQ-008 XUDS, XLDS  in  1 each  Upper and lower data strobes, active-low, asynchronous.
REQ-009 XRW  in  1  1 = read, 0 = write.
REQ-010 DIN  in  16  Write data from the bus.
REQ-011 DOUT  out  16  Read data to the bus.
REQ-012 DOE  out  1  High = drive DOUT onto D[15:0].
REQ-013 XDTACK_OE  out  1  High = pull XDTACK low; low = release (open-drain emulation).
REQ-014 STATUS_IN  in  8  Live status bits, sampled on reads.
REQ-015 CTRL  out  16  Current CTRL register contents.
REQ-016 BUSY  out  1  High whenever the FSM is not in IDLE.

Function
REQ-017 XAS, XUDS and XLDS SHALL each pass through a 2-flop synchronizer; the FSM uses only the synchronized copies as_s, uds_s and lds_s.
REQ-018 The FSM SHALL have the states IDLE, WAIT, ACK and IGNORE.
REQ-019 In IDLE, when as_s=0 and (uds_s=0 or lds_s=0):
- if A[23:16]=BASE_ADDR and A[15:4]=0, go to WAIT; else go to IGNORE.
REQ-020 On the IDLE->WAIT transition the block SHALL latch A[3:1], XRW, both lane enables and DIN, and load a wait counter with WAIT_STATES.
REQ-021 WAIT SHALL do the following:
- if as_s=1, return to IDLE (abort): no register write, no DTACK.
- otherwise, if the counter is 0, go to ACK; else decrement the counter.
REQ-022 ACK SHALL hold XDTACK_OE=1, with DOE=XRW_latched, until as_s=1, then go to IDLE.
REQ-023 A write SHALL occur exactly once, on the WAIT->ACK transition, and only to the byte lanes latched active.
- UDS lane writes bits 15:8; LDS lane writes bits 7:0.
REQ-024 IGNORE SHALL stay until as_s=1 and SHALL never assert XDTACK_OE or DOE; the bus-error path is external to this block.
REQ-025 Register map by A[3:1]:
- 0: CTRL, read/write.
- 1: STATUS, read-only, {8'h00, STATUS_IN}.
- 2: SCRATCH, read/write.
- 3: ID, read-only, ID_VALUE.
- 4-7: read 16'h0000, writes discarded.
- All of these offsets are acknowledged.
REQ-026 Writes to read-only offsets SHALL be acknowledged and SHALL change no state.
REQ-027 DOUT SHALL be registered on the WAIT->ACK transition and held stable through ACK; STATUS_IN is sampled at that edge.
REQ-028 XDTACK_OE SHALL be registered.
- Assertion: on rising edge 4+WAIT_STATES, counting the edge that first samples XAS low as edge 1.
- Release: on edge 3 counting the edge that first samples XAS high as edge 1.
REQ-029 A new cycle SHALL NOT be recognized until the FSM has returned to IDLE; back-to-back cycles therefore need XAS high for at least 3 clocks.
REQ-030 If as_s=0 while both data strobes are still high (address phase only), IDLE SHALL wait and make no transition.
REQ-031 A decode SHALL use A as sampled in the transition cycle; the 68000 guarantees that A is stable while XAS is low.

Reset
REQ-032 While RST=0 at a rising edge, the block SHALL reset to:
- FSM in IDLE; wait counter 0;
- CTRL=16'h0000, SCRATCH=16'h0000;
- DOUT=16'h0000, DOE=0, XDTACK_OE=0, BUSY=0;
- synchronizer flops all 1.
REQ-033 A reset that arrives mid-cycle SHALL release XDTACK_OE and DOE on that edge. After reset the still-low XAS SHALL be handled as follows:
- the synchronizers refill from 1, so the low XAS is re-sampled and the cycle is re-decoded once RST returns high;
- the bench must accept this cycle being answered after reset.

Verification
REQ-034 Word write $F10000=16'hA5C3, both strobes, WAIT_STATES=2 -> XDTACK_OE rises on edge 6; CTRL=16'hA5C3 after ACK; XDTACK_OE falls on the 3rd edge after XAS rises.
REQ-035 Byte write $F10004 with only XLDS low, DIN=16'hFF12, SCRATCH previously 16'h3456 -> SCRATCH=16'h3412.
REQ-036 Read $F10006 -> DOUT=16'hDFB1 and DOE=1 throughout ACK. Read $F10002 with STATUS_IN=8'h5A -> DOUT=16'h005A.
REQ-037 Access to $F20000, and to $F10010, -> FSM enters IGNORE; XDTACK_OE and DOE stay 0 for the whole cycle; BUSY=1 until XAS rises.
REQ-038 Write to $F10000 with XAS deasserted at the 2nd edge of WAIT (WAIT_STATES=4) -> no DTACK; CTRL unchanged; FSM back in IDLE.
REQ-039 RST pulsed low during ACK of a CTRL write -> XDTACK_OE=0 and CTRL=16'h0000 at the reset edge; with XAS still low after RST rises, the cycle is answered anew.
